// File: rtl/z80_bus_responder.sv
// Z80 bus target: decodes CPU bus cycles, forwards them to a local req/ack port, stretches with WAIT, and serves INTA vectors.
// Optional local-ack timeout is enabled by defining Z80_RESP_TIMEOUT_EN.
module z80_bus_responder #(
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1,
    parameter int TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m1,
    input  logic        mreq,
    input  logic        iorq,
    input  logic        rd,
    input  logic        wr,
    input  logic        rfsh,
    input  logic [15:0] addr,
    input  logic [7:0]  db_in,
    output logic [7:0]  db_out,
    output logic        db_oe,
    output logic        mwait,
    output logic        intr,
    output logic        lreq,
    output logic        lwe,
    output logic        lio,
    output logic [15:0] laddr,
    output logic [7:0]  lwdata,
    input  logic [7:0]  lrdata,
    input  logic        lack,
    input  logic        irq,
    input  logic [7:0]  int_vec,
    output logic        err
);

    localparam int WAIT_MAX = (MEM_WAIT > IO_WAIT) ? MEM_WAIT : IO_WAIT;
    localparam int CNT_W    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic [CNT_W-1:0] MEM_LOAD = CNT_W'(MEM_WAIT);
    localparam logic [CNT_W-1:0] IO_LOAD  = CNT_W'(IO_WAIT);

    if (MEM_WAIT < 0 || IO_WAIT < 0 || TIMEOUT < 1) begin : g_param_check
        $error("z80_bus_responder: wait counts must be >= 0 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WCNT,
        S_HOLD
    } state_t;

    typedef enum logic [2:0] {
        CYC_NONE,
        CYC_INTA,
        CYC_RFSH,
        CYC_MRD,
        CYC_MWR,
        CYC_IORD,
        CYC_IOWR
    } cyc_t;

    state_t           state, state_nxt;
    cyc_t             cyc;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [7:0]       db_out_nxt;
    logic             db_oe_nxt, mwait_nxt, int_pending_nxt;
    logic             lreq_nxt, lwe_nxt, lio_nxt;
    logic [15:0]      laddr_nxt;
    logic [7:0]       lwdata_nxt;
    logic             bus_idle;

`ifdef Z80_RESP_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic            err_nxt;
`else
    // Without the timeout the local side is trusted to answer eventually.
    assign err = 1'b0;
`endif

    // Refresh outranks memory decode so RFSH cycles never reach the local port.
    always_comb begin
        if (m1 && iorq)                 cyc = CYC_INTA;
        else if (rfsh && mreq)          cyc = CYC_RFSH;
        else if (mreq && rd && !rfsh)   cyc = CYC_MRD;
        else if (mreq && wr)            cyc = CYC_MWR;
        else if (iorq && rd && !m1)     cyc = CYC_IORD;
        else if (iorq && wr && !m1)     cyc = CYC_IOWR;
        else                            cyc = CYC_NONE;
    end

    assign bus_idle = !(rd || wr || mreq || iorq);

    always_comb begin
        // NOTE: every next-state value defaults to "hold" first, so no path through the case infers a latch.
        state_nxt       = state;
        wait_cnt_nxt    = wait_cnt;
        db_out_nxt      = db_out;
        db_oe_nxt       = db_oe;
        mwait_nxt       = mwait;
        int_pending_nxt = intr;
        lreq_nxt        = lreq;
        lwe_nxt         = lwe;
        lio_nxt         = lio;
        laddr_nxt       = laddr;
        lwdata_nxt      = lwdata;
`ifdef Z80_RESP_TIMEOUT_EN
        to_cnt_nxt      = to_cnt;
        err_nxt         = err;
`endif

        unique case (state)
            S_IDLE: begin
                unique case (cyc)
                    CYC_INTA: begin
                        db_out_nxt      = int_vec;
                        db_oe_nxt       = 1'b1;
                        int_pending_nxt = 1'b0;
                        state_nxt       = S_HOLD;
                    end
                    CYC_MRD, CYC_MWR, CYC_IORD, CYC_IOWR: begin
                        laddr_nxt    = addr;
                        lwdata_nxt   = db_in;
                        lwe_nxt      = (cyc == CYC_MWR) || (cyc == CYC_IOWR);
                        lio_nxt      = (cyc == CYC_IORD) || (cyc == CYC_IOWR);
                        lreq_nxt     = 1'b1;
                        mwait_nxt    = 1'b1;
                        wait_cnt_nxt = lio_nxt ? IO_LOAD : MEM_LOAD;
`ifdef Z80_RESP_TIMEOUT_EN
                        to_cnt_nxt   = '0;
`endif
                        state_nxt    = S_REQ;
                    end
                    default: ;
                endcase
            end

            S_REQ: begin
                if (lack) begin
                    lreq_nxt = 1'b0;
                    if (!lwe) db_out_nxt = lrdata;
                    if (wait_cnt == '0) begin
                        mwait_nxt = 1'b0;
                        db_oe_nxt = !lwe;
                        state_nxt = S_HOLD;
                    end else begin
                        state_nxt = S_WCNT;
                    end
                end
`ifdef Z80_RESP_TIMEOUT_EN
                else if (to_cnt == TO_LAST) begin
                    lreq_nxt   = 1'b0;
                    db_out_nxt = 8'hFF;
                    err_nxt    = 1'b1;
                    mwait_nxt  = 1'b0;
                    db_oe_nxt  = !lwe;
                    state_nxt  = S_HOLD;
                end else begin
                    to_cnt_nxt = to_cnt + 1'b1;
                end
`endif
            end

            S_WCNT: begin
                wait_cnt_nxt = wait_cnt - 1'b1;
                if (wait_cnt == CNT_W'(1)) begin
                    mwait_nxt = 1'b0;
                    db_oe_nxt = !lwe;
                    state_nxt = S_HOLD;
                end
            end

            // Waiting for the CPU to release the strobes keeps one bus cycle from being decoded twice.
            S_HOLD: begin
                if (bus_idle) begin
                    db_oe_nxt = 1'b0;
                    state_nxt = S_IDLE;
                end
            end

            default: state_nxt = S_IDLE;
        endcase

        // A set strobe on the acknowledge edge beats the clear.
        if (irq) int_pending_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            db_out   <= '0;
            db_oe    <= 1'b0;
            mwait    <= 1'b0;
            intr     <= 1'b0;
            lreq     <= 1'b0;
            lwe      <= 1'b0;
            lio      <= 1'b0;
            laddr    <= '0;
            lwdata   <= '0;
`ifdef Z80_RESP_TIMEOUT_EN
            to_cnt   <= '0;
            err      <= 1'b0;
`endif
        end else begin
            // NOTE: registers take their next value with non-blocking assignments so every flop samples the same pre-edge state.
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            db_out   <= db_out_nxt;
            db_oe    <= db_oe_nxt;
            mwait    <= mwait_nxt;
            intr     <= int_pending_nxt;
            lreq     <= lreq_nxt;
            lwe      <= lwe_nxt;
            lio      <= lio_nxt;
            laddr    <= laddr_nxt;
            lwdata   <= lwdata_nxt;
`ifdef Z80_RESP_TIMEOUT_EN
            to_cnt   <= to_cnt_nxt;
            err      <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: bus cycle decode, WAIT stretching, INTA vectors, reset abort and optional timeout.
module tb_z80_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        m1, mreq, iorq, rd, wr, rfsh;
    logic [15:0] addr;
    logic [7:0]  db_in;
    logic [7:0]  db_out;
    logic        db_oe, mwait, intr, lreq, lwe, lio;
    logic [15:0] laddr;
    logic [7:0]  lwdata;
    logic [7:0]  lrdata;
    logic        lack, irq;
    logic [7:0]  int_vec;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    z80_bus_responder #(
        .MEM_WAIT(0),
        .IO_WAIT (1),
        .TIMEOUT (4)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .m1     (m1),
        .mreq   (mreq),
        .iorq   (iorq),
        .rd     (rd),
        .wr     (wr),
        .rfsh   (rfsh),
        .addr   (addr),
        .db_in  (db_in),
        .db_out (db_out),
        .db_oe  (db_oe),
        .mwait  (mwait),
        .intr   (intr),
        .lreq   (lreq),
        .lwe    (lwe),
        .lio    (lio),
        .laddr  (laddr),
        .lwdata (lwdata),
        .lrdata (lrdata),
        .lack   (lack),
        .irq    (irq),
        .int_vec(int_vec),
        .err    (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop_strobes();
        m1 = 1'b0; mreq = 1'b0; iorq = 1'b0; rd = 1'b0; wr = 1'b0; rfsh = 1'b0;
    endtask

    // Called just after the detect edge; lack is seen on edge number lack_delay (0 = never).
    task automatic run_bus_cycle(input int lack_delay, input logic [7:0] rdata,
                                 output int lreq_cycles, output int mwait_cycles,
                                 output logic oe_seen);
        lreq_cycles  = 0;
        mwait_cycles = 0;
        oe_seen      = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (lreq)  lreq_cycles++;
            if (mwait) mwait_cycles++;
            if (!lreq && !mwait) break;
            if (db_oe) oe_seen = 1'b1;
            lack   = (i == lack_delay - 1);
            lrdata = rdata;
            tick();
            lack = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drop_strobes();
        addr = '0; db_in = '0; lrdata = '0; lack = 1'b0; irq = 1'b0; int_vec = '0;
        repeat (3) tick();
        n_checks++;
        if ({db_out, db_oe, mwait, intr, lreq, lwe, lio, laddr, lwdata, err} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got db_out=%h db_oe=%b mwait=%b intr=%b lreq=%b lwe=%b lio=%b laddr=%h lwdata=%h err=%b, expected all zero",
                     db_out, db_oe, mwait, intr, lreq, lwe, lio, laddr, lwdata, err);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_mem_read();
        int   lc, mc;
        logic oe;
        addr = 16'h1234; mreq = 1'b1; rd = 1'b1;
        tick();
        n_checks++;
        if ({laddr, lwe, lio} !== {16'h1234, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mrd_attrs: got laddr=%h lwe=%b lio=%b, expected 1234 0 0", laddr, lwe, lio);
        end
        run_bus_cycle(3, 8'hA5, lc, mc, oe);
        n_checks++;
        if (lc !== 3) begin n_fail++; $display("FAIL mrd_lreq_len: got %0d, expected 3", lc); end
        n_checks++;
        if (mc !== 3) begin n_fail++; $display("FAIL mrd_mwait_len: got %0d, expected 3", mc); end
        n_checks++;
        if ({db_out, db_oe} !== {8'hA5, 1'b1}) begin
            n_fail++;
            $display("FAIL mrd_data: got db_out=%h db_oe=%b, expected a5 1", db_out, db_oe);
        end
        tick();
        n_checks++;
        if ({db_oe, lreq} !== 2'b10) begin
            n_fail++;
            $display("FAIL mrd_hold: got db_oe=%b lreq=%b, expected 1 0", db_oe, lreq);
        end
        drop_strobes();
        tick();
        n_checks++;
        if (db_oe !== 1'b0) begin n_fail++; $display("FAIL mrd_release: got db_oe=%b, expected 0", db_oe); end
    endtask

    task automatic test_io_write();
        int   lc, mc;
        logic oe;
        addr = 16'h0042; db_in = 8'h5A; iorq = 1'b1; wr = 1'b1;
        tick();
        n_checks++;
        if ({laddr, lwdata, lwe, lio} !== {16'h0042, 8'h5A, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL iowr_attrs: got laddr=%h lwdata=%h lwe=%b lio=%b, expected 0042 5a 1 1", laddr, lwdata, lwe, lio);
        end
        run_bus_cycle(1, 8'h00, lc, mc, oe);
        n_checks++;
        if (lc !== 1) begin n_fail++; $display("FAIL iowr_lreq_len: got %0d, expected 1", lc); end
        n_checks++;
        if (mc !== 2) begin n_fail++; $display("FAIL iowr_mwait_len: got %0d, expected 2", mc); end
        n_checks++;
        if ({oe, db_oe} !== 2'b00) begin
            n_fail++;
            $display("FAIL iowr_no_oe: got seen=%b now=%b, expected 0 0", oe, db_oe);
        end
        drop_strobes();
        tick();
    endtask

    task automatic test_refresh();
        addr = 16'h007F; rfsh = 1'b1; mreq = 1'b1;
        repeat (2) begin
            tick();
            n_checks++;
            if ({lreq, mwait, db_oe} !== 3'b000) begin
                n_fail++;
                $display("FAIL rfsh_ignored: got lreq=%b mwait=%b db_oe=%b, expected 0 0 0", lreq, mwait, db_oe);
            end
        end
        drop_strobes();
        tick();
    endtask

    task automatic test_inta();
        irq = 1'b1;
        tick();
        irq = 1'b0;
        n_checks++;
        if (intr !== 1'b1) begin n_fail++; $display("FAIL irq_set: got intr=%b, expected 1", intr); end
        int_vec = 8'hFF; m1 = 1'b1; iorq = 1'b1;
        tick();
        n_checks++;
        if ({db_out, db_oe, intr, mwait, lreq} !== {8'hFF, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL inta_vec: got db_out=%h db_oe=%b intr=%b mwait=%b lreq=%b, expected ff 1 0 0 0",
                     db_out, db_oe, intr, mwait, lreq);
        end
        drop_strobes();
        tick();
        n_checks++;
        if (db_oe !== 1'b0) begin n_fail++; $display("FAIL inta_release: got db_oe=%b, expected 0", db_oe); end
    endtask

    task automatic test_inta_irq_collision();
        irq = 1'b1;
        tick();
        int_vec = 8'h38; m1 = 1'b1; iorq = 1'b1;
        tick();
        irq = 1'b0;
        n_checks++;
        if ({intr, db_out, db_oe} !== {1'b1, 8'h38, 1'b1}) begin
            n_fail++;
            $display("FAIL inta_collision: got intr=%b db_out=%h db_oe=%b, expected 1 38 1", intr, db_out, db_oe);
        end
        drop_strobes();
        tick();
        n_checks++;
        if ({intr, db_oe} !== 2'b10) begin
            n_fail++;
            $display("FAIL inta_collision_after: got intr=%b db_oe=%b, expected 1 0", intr, db_oe);
        end
    endtask

    task automatic test_reset_mid_cycle();
        addr = 16'hABCD; mreq = 1'b1; rd = 1'b1;
        tick();
        n_checks++;
        if (lreq !== 1'b1) begin n_fail++; $display("FAIL rst_pre_lreq: got %b, expected 1", lreq); end
        reset = 1'b1;
        drop_strobes();
        tick();
        n_checks++;
        if ({lreq, mwait, db_oe, intr, laddr} !== {4'b0000, 16'h0000}) begin
            n_fail++;
            $display("FAIL rst_abort: got lreq=%b mwait=%b db_oe=%b intr=%b laddr=%h, expected 0 0 0 0 0000",
                     lreq, mwait, db_oe, intr, laddr);
        end
        reset = 1'b0;
        tick();
        lack = 1'b1; lrdata = 8'hEE;
        tick();
        lack = 1'b0;
        tick();
        n_checks++;
        if ({lreq, mwait, db_oe, db_out} !== {3'b000, 8'h00}) begin
            n_fail++;
            $display("FAIL stray_lack: got lreq=%b mwait=%b db_oe=%b db_out=%h, expected 0 0 0 00",
                     lreq, mwait, db_oe, db_out);
        end
    endtask

    task automatic test_back_to_back();
        int   lc, mc;
        logic oe;
        addr = 16'h8000; db_in = 8'h3C; mreq = 1'b1; wr = 1'b1;
        tick();
        n_checks++;
        if ({laddr, lwdata, lwe, lio} !== {16'h8000, 8'h3C, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL mwr_attrs: got laddr=%h lwdata=%h lwe=%b lio=%b, expected 8000 3c 1 0", laddr, lwdata, lwe, lio);
        end
        run_bus_cycle(1, 8'h00, lc, mc, oe);
        n_checks++;
        if ({lc, mc} !== {32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL mwr_lens: got lreq=%0d mwait=%0d, expected 1 1", lc, mc);
        end
        tick();
        n_checks++;
        if ({lreq, oe, db_oe} !== 3'b000) begin
            n_fail++;
            $display("FAIL mwr_no_redetect: got lreq=%b oe_seen=%b db_oe=%b, expected 0 0 0", lreq, oe, db_oe);
        end
        drop_strobes();
        tick();
        addr = 16'h00FE; iorq = 1'b1; rd = 1'b1;
        tick();
        n_checks++;
        if ({laddr, lwe, lio} !== {16'h00FE, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL iord_attrs: got laddr=%h lwe=%b lio=%b, expected 00fe 0 1", laddr, lwe, lio);
        end
        run_bus_cycle(2, 8'h77, lc, mc, oe);
        n_checks++;
        if ({lc, mc} !== {32'd2, 32'd3}) begin
            n_fail++;
            $display("FAIL iord_lens: got lreq=%0d mwait=%0d, expected 2 3", lc, mc);
        end
        n_checks++;
        if ({db_out, db_oe} !== {8'h77, 1'b1}) begin
            n_fail++;
            $display("FAIL iord_data: got db_out=%h db_oe=%b, expected 77 1", db_out, db_oe);
        end
        drop_strobes();
        tick();
        n_checks++;
        if (db_oe !== 1'b0) begin n_fail++; $display("FAIL iord_release: got db_oe=%b, expected 0", db_oe); end
    endtask

`ifdef Z80_RESP_TIMEOUT_EN
    task automatic test_timeout();
        int   lc, mc;
        logic oe;
        addr = 16'h4000; mreq = 1'b1; rd = 1'b1;
        tick();
        run_bus_cycle(0, 8'h00, lc, mc, oe);
        n_checks++;
        if ({lc, mc} !== {32'd4, 32'd4}) begin
            n_fail++;
            $display("FAIL to_lens: got lreq=%0d mwait=%0d, expected 4 4", lc, mc);
        end
        n_checks++;
        if ({db_out, db_oe, err} !== {8'hFF, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL to_result: got db_out=%h db_oe=%b err=%b, expected ff 1 1", db_out, db_oe, err);
        end
        drop_strobes();
        tick();
        lack = 1'b1; lrdata = 8'h11;
        tick();
        lack = 1'b0;
        tick();
        n_checks++;
        if ({err, lreq, db_out} !== {1'b1, 1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL to_sticky: got err=%b lreq=%b db_out=%h, expected 1 0 ff", err, lreq, db_out);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL to_reset_clear: got err=%b, expected 0", err); end
    endtask
`endif

    initial begin
        test_reset();
        test_mem_read();
        test_io_write();
        test_refresh();
        test_back_to_back();
        test_inta();
        test_inta_irq_collision();
        test_reset_mid_cycle();
`ifdef Z80_RESP_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
